// File: rtl/tg_sink_pkg.sv
// Shared definitions for the traffic-generator packet sink: flit field positions,
// FSM state type and rx_error bit indices.
package tg_sink_pkg;

   localparam int FLIT_W      = 36;
   localparam int BIT_VALID   = 35;
   localparam int BIT_HEAD    = 34;
   localparam int BIT_TAIL    = 33;
   localparam int BIT_MEASURE = 32;
   localparam int DEST_MSB    = 31;
   localparam int DEST_LSB    = 24;
   localparam int TS_MSB      = 23;
   localparam int TS_LSB      = 14;
   localparam int PSIZE_MSB   = 13;
   localparam int PSIZE_LSB   = 4;
   localparam int PSIZE_W     = PSIZE_MSB - PSIZE_LSB + 1;

   typedef enum logic {
      IDLE = 1'b0,
      RECV = 1'b1
   } sink_state_e;

   localparam int ERR_DEST = 0;
   localparam int ERR_SEQ  = 1;
   localparam int ERR_LEN  = 2;

endpackage

// File: rtl/tg_sink_stats.sv
// Receive statistics for the packet sink: packet counters, saturating latency sum,
// last latency and, with TG_SINK_MAX_LATENCY_EN defined, the maximum latency.
module tg_sink_stats #(
   parameter int TS_WIDTH  = 10,
   parameter int CNT_WIDTH = 16,
   parameter int SUM_WIDTH = 32
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 done,
   input  logic                 measure,
   input  logic [TS_WIDTH-1:0]  latency,
   output logic                 packet_done,
   output logic [CNT_WIDTH-1:0] rx_packets,
   output logic [CNT_WIDTH-1:0] rx_measured,
   output logic [SUM_WIDTH-1:0] latency_sum,
   output logic [TS_WIDTH-1:0]  last_latency,
   output logic [TS_WIDTH-1:0]  max_latency
);

   logic                 packet_done_q, packet_done_d;
   logic [CNT_WIDTH-1:0] rx_packets_q, rx_packets_d;
   logic [CNT_WIDTH-1:0] rx_measured_q, rx_measured_d;
   logic [SUM_WIDTH-1:0] latency_sum_q, latency_sum_d;
   logic [TS_WIDTH-1:0]  last_latency_q, last_latency_d;
   logic [SUM_WIDTH:0]   sum_ext;

   // clear overrides a coincident completion, but the done pulse still goes out
   always_comb begin
      packet_done_d  = done;
      rx_packets_d   = rx_packets_q;
      rx_measured_d  = rx_measured_q;
      latency_sum_d  = latency_sum_q;
      last_latency_d = last_latency_q;
      sum_ext        = {1'b0, latency_sum_q} + {{(SUM_WIDTH + 1 - TS_WIDTH){1'b0}}, latency};
      if (done) begin
         rx_packets_d = rx_packets_q + 1'b1;
         if (measure) begin
            rx_measured_d  = rx_measured_q + 1'b1;
            last_latency_d = latency;
            latency_sum_d  = sum_ext[SUM_WIDTH] ? {SUM_WIDTH{1'b1}} : sum_ext[SUM_WIDTH-1:0];
         end
      end
      if (clear) begin
         rx_packets_d   = '0;
         rx_measured_d  = '0;
         latency_sum_d  = '0;
         last_latency_d = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         packet_done_q  <= 1'b0;
         rx_packets_q   <= '0;
         rx_measured_q  <= '0;
         latency_sum_q  <= '0;
         last_latency_q <= '0;
      end else begin
         packet_done_q  <= packet_done_d;
         rx_packets_q   <= rx_packets_d;
         rx_measured_q  <= rx_measured_d;
         latency_sum_q  <= latency_sum_d;
         last_latency_q <= last_latency_d;
      end
   end

   assign packet_done  = packet_done_q;
   assign rx_packets   = rx_packets_q;
   assign rx_measured  = rx_measured_q;
   assign latency_sum  = latency_sum_q;
   assign last_latency = last_latency_q;

`ifdef TG_SINK_MAX_LATENCY_EN
   logic [TS_WIDTH-1:0] max_latency_q, max_latency_d;

   always_comb begin
      max_latency_d = max_latency_q;
      if (done && measure && (latency > max_latency_q)) begin
         max_latency_d = latency;
      end
      if (clear) begin
         max_latency_d = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         max_latency_q <= '0;
      end else begin
         max_latency_q <= max_latency_d;
      end
   end

   assign max_latency = max_latency_q;
`else
   assign max_latency = '0;
`endif

endmodule

// File: rtl/tg_packet_sink.sv
// Packet sink: reassembles ejected flits, checks dest/sequence/length and feeds
// tg_sink_stats. Optional max-latency tracking via TG_SINK_MAX_LATENCY_EN.
module tg_packet_sink
   import tg_sink_pkg::*;
#(
   parameter int TS_WIDTH  = 10,
   parameter int CNT_WIDTH = 16,
   parameter int SUM_WIDTH = 32
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [7:0]           my_addr,
   input  logic [TS_WIDTH-1:0]  sim_time,
   input  logic                 clear_stats,
   input  logic [FLIT_W-1:0]    flit_in,
   output logic                 packet_done,
   output logic [CNT_WIDTH-1:0] rx_packets,
   output logic [CNT_WIDTH-1:0] rx_measured,
   output logic [SUM_WIDTH-1:0] latency_sum,
   output logic [TS_WIDTH-1:0]  last_latency,
   output logic [2:0]           rx_error,
   output logic [TS_WIDTH-1:0]  max_latency
);

   sink_state_e          state_q, state_d;
   logic [PSIZE_W-1:0]   remaining_q, remaining_d;
   logic                 measure_q, measure_d;
   logic                 dest_ok_q, dest_ok_d;
   logic [TS_WIDTH-1:0]  ts_q, ts_d;
   logic [2:0]           err_q, err_d;

   logic                 accept, start_head;
   logic                 f_head, f_tail, f_measure, f_dest_ok;
   logic [TS_WIDTH-1:0]  f_ts;
   logic [PSIZE_W-1:0]   f_psize;
   logic                 cmp_done, cmp_measure;
   logic [TS_WIDTH-1:0]  cmp_ts, cmp_latency;
   logic                 unused_rsvd;

   assign accept      = enable & flit_in[BIT_VALID];
   assign f_head      = flit_in[BIT_HEAD];
   assign f_tail      = flit_in[BIT_TAIL];
   assign f_measure   = flit_in[BIT_MEASURE];
   assign f_dest_ok   = (flit_in[DEST_MSB:DEST_LSB] == my_addr);
   assign f_ts        = TS_WIDTH'(flit_in[TS_MSB:TS_LSB]);
   assign f_psize     = flit_in[PSIZE_MSB:PSIZE_LSB];
   assign unused_rsvd = ^flit_in[PSIZE_LSB-1:0];

   // A head seen mid-packet abandons the current packet and restarts as an IDLE head
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      measure_d   = measure_q;
      dest_ok_d   = dest_ok_q;
      ts_d        = ts_q;
      err_d       = err_q;
      start_head  = 1'b0;
      cmp_done    = 1'b0;
      cmp_measure = measure_q;
      cmp_ts      = ts_q;
      if (accept) begin
         unique case (state_q)
            IDLE: begin
               if (f_head) start_head = 1'b1;
               else        err_d[ERR_SEQ] = 1'b1;
            end
            RECV: begin
               if (f_head) begin
                  err_d[ERR_SEQ] = 1'b1;
                  start_head     = 1'b1;
                  state_d        = IDLE;
               end else if (remaining_q == PSIZE_W'(1)) begin
                  state_d = IDLE;
                  if (f_tail) cmp_done = dest_ok_q;
                  else        err_d[ERR_LEN] = 1'b1;
               end else if (f_tail) begin
                  err_d[ERR_LEN] = 1'b1;
                  state_d        = IDLE;
               end else begin
                  remaining_d = remaining_q - PSIZE_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
         if (start_head) begin
            measure_d   = f_measure;
            ts_d        = f_ts;
            dest_ok_d   = f_dest_ok;
            remaining_d = f_psize - PSIZE_W'(1);
            if (!f_dest_ok) err_d[ERR_DEST] = 1'b1;
            if (f_psize == '0) begin
               err_d[ERR_LEN] = 1'b1;
               state_d        = IDLE;
            end else if (f_psize == PSIZE_W'(1)) begin
               state_d = IDLE;
               if (f_tail) begin
                  cmp_done    = f_dest_ok;
                  cmp_measure = f_measure;
                  cmp_ts      = f_ts;
               end else begin
                  err_d[ERR_LEN] = 1'b1;
               end
            end else begin
               state_d = RECV;
            end
         end
      end
      if (clear_stats) err_d = '0;
      cmp_latency = sim_time - cmp_ts;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         measure_q   <= 1'b0;
         dest_ok_q   <= 1'b0;
         ts_q        <= '0;
         err_q       <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         measure_q   <= measure_d;
         dest_ok_q   <= dest_ok_d;
         ts_q        <= ts_d;
         err_q       <= err_d;
      end
   end

   assign rx_error = err_q;

   tg_sink_stats #(
      .TS_WIDTH  (TS_WIDTH),
      .CNT_WIDTH (CNT_WIDTH),
      .SUM_WIDTH (SUM_WIDTH)
   ) u_stats (
      .clock        (clock),
      .reset        (reset),
      .clear        (clear_stats),
      .done         (cmp_done),
      .measure      (cmp_measure),
      .latency      (cmp_latency),
      .packet_done  (packet_done),
      .rx_packets   (rx_packets),
      .rx_measured  (rx_measured),
      .latency_sum  (latency_sum),
      .last_latency (last_latency),
      .max_latency  (max_latency)
   );

endmodule

// File: tb/tb_tg_packet_sink.sv
// Self-checking bench for tg_packet_sink: flit-counting reference model compared every
// cycle, plus literal expectations. Honours TG_SINK_MAX_LATENCY_EN.
module tb_tg_packet_sink;

   logic        clock = 1'b0;
   logic        reset, enable, clear_stats;
   logic [7:0]  my_addr;
   logic [9:0]  sim_time;
   logic [35:0] flit_in;

   logic        packet_done,  s_done;
   logic [15:0] rx_packets,   s_packets;
   logic [15:0] rx_measured,  s_measured;
   logic [31:0] latency_sum;
   logic [10:0] s_sum;
   logic [9:0]  last_latency, s_last;
   logic [2:0]  rx_error,     s_err;
   logic [9:0]  max_latency,  s_max;

   int checks = 0;
   int errors = 0;
   bit chk_on = 1'b0;

   bit     m_in_pkt, m_meas, m_dok;
   int     m_need, m_got, m_ts;
   bit     exp_done;
   int     exp_pkts, exp_meas, exp_last, exp_max;
   longint exp_sum, exp_ssum;
   bit [2:0] exp_err;

   always #5 clock = ~clock;

   tg_packet_sink dut (
      .clock(clock), .reset(reset), .enable(enable), .my_addr(my_addr),
      .sim_time(sim_time), .clear_stats(clear_stats), .flit_in(flit_in),
      .packet_done(packet_done), .rx_packets(rx_packets), .rx_measured(rx_measured),
      .latency_sum(latency_sum), .last_latency(last_latency), .rx_error(rx_error),
      .max_latency(max_latency)
   );

   // Narrow accumulator instance so saturation is reachable in a short run
   tg_packet_sink #(.SUM_WIDTH(11)) u_small (
      .clock(clock), .reset(reset), .enable(enable), .my_addr(my_addr),
      .sim_time(sim_time), .clear_stats(clear_stats), .flit_in(flit_in),
      .packet_done(s_done), .rx_packets(s_packets), .rx_measured(s_measured),
      .latency_sum(s_sum), .last_latency(s_last), .rx_error(s_err),
      .max_latency(s_max)
   );

   function automatic logic [35:0] mk_flit(input bit h, input bit t, input bit m,
                                           input logic [7:0] d, input logic [9:0] ts,
                                           input logic [9:0] ps);
      return {1'b1, h, t, m, d, ts, ps, 4'b0000};
   endfunction

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply_stimulus(input logic [35:0] f, input logic [9:0] t,
                                 input bit en, input bit clr);
      @(negedge clock);
      flit_in     = f;
      sim_time    = t;
      enable      = en;
      clear_stats = clr;
   endtask

   task automatic idle_cycle();
      apply_stimulus(36'h0, sim_time, 1'b1, 1'b0);
   endtask

   // Reference model: counts flits against the head's psize, one step per clock
   always @(posedge clock) begin
      bit fin;
      int lat;
      int ps;
      if (reset) begin
         m_in_pkt = 0; m_meas = 0; m_dok = 0; m_need = 0; m_got = 0; m_ts = 0;
         exp_done = 0; exp_pkts = 0; exp_meas = 0; exp_last = 0; exp_max = 0;
         exp_sum = 0; exp_ssum = 0; exp_err = 3'b000;
      end else begin
         fin = 0;
         exp_done = 0;
         if (enable && flit_in[35]) begin
            if (flit_in[34]) begin
               if (m_in_pkt) exp_err[1] = 1'b1;
               m_in_pkt = 0;
               m_meas   = flit_in[32];
               m_ts     = int'(flit_in[23:14]);
               m_dok    = (flit_in[31:24] == my_addr);
               if (!m_dok) exp_err[0] = 1'b1;
               ps     = int'(flit_in[13:4]);
               m_need = ps;
               m_got  = 1;
               if (ps == 0) exp_err[2] = 1'b1;
               else if (ps == 1) begin
                  if (flit_in[33]) fin = 1;
                  else exp_err[2] = 1'b1;
               end else m_in_pkt = 1;
            end else if (!m_in_pkt) begin
               exp_err[1] = 1'b1;
            end else begin
               m_got++;
               if (m_got == m_need) begin
                  m_in_pkt = 0;
                  if (flit_in[33]) fin = 1;
                  else exp_err[2] = 1'b1;
               end else if (flit_in[33]) begin
                  m_in_pkt = 0;
                  exp_err[2] = 1'b1;
               end
            end
         end
         if (fin && m_dok) begin
            exp_done = 1;
            exp_pkts = (exp_pkts + 1) % 65536;
            if (m_meas) begin
               lat      = (int'(sim_time) - m_ts + 1024) % 1024;
               exp_meas = (exp_meas + 1) % 65536;
               exp_last = lat;
               exp_sum  = (exp_sum + lat > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : exp_sum + lat;
               exp_ssum = (exp_ssum + lat > 2047) ? 2047 : exp_ssum + lat;
`ifdef TG_SINK_MAX_LATENCY_EN
               if (lat > exp_max) exp_max = lat;
`endif
            end
         end
         if (clear_stats) begin
            exp_pkts = 0; exp_meas = 0; exp_last = 0; exp_max = 0;
            exp_sum = 0; exp_ssum = 0; exp_err = 3'b000;
         end
      end
   end

   always @(negedge clock) begin
      if (chk_on) begin
         check_output("packet_done",  packet_done,  exp_done);
         check_output("rx_packets",   rx_packets,   exp_pkts);
         check_output("rx_measured",  rx_measured,  exp_meas);
         check_output("latency_sum",  latency_sum,  exp_sum);
         check_output("last_latency", last_latency, exp_last);
         check_output("rx_error",     rx_error,     exp_err);
         check_output("max_latency",  max_latency,  exp_max);
         check_output("s_done",       s_done,       exp_done);
         check_output("s_packets",    s_packets,    exp_pkts);
         check_output("s_measured",   s_measured,   exp_meas);
         check_output("s_sum",        s_sum,        exp_ssum);
         check_output("s_last",       s_last,       exp_last);
         check_output("s_err",        s_err,        exp_err);
         check_output("s_max",        s_max,        exp_max);
      end
   end

   initial begin
      reset = 1'b1; enable = 1'b0; clear_stats = 1'b0;
      my_addr = 8'hCA; sim_time = '0; flit_in = '0;
      @(negedge clock);
      chk_on = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check_output("lit_reset_pkts", rx_packets, 0);
      check_output("lit_reset_err",  rx_error,   0);
      check_output("lit_reset_done", packet_done, 0);

      $display("[TB] single flit packet");
      apply_stimulus(mk_flit(1, 1, 1, 8'hCA, 10'd3, 10'd1), 10'd7, 1, 0);
      idle_cycle();
      check_output("lit_t1_done", packet_done,  1);
      check_output("lit_t1_pkts", rx_packets,   1);
      check_output("lit_t1_meas", rx_measured,  1);
      check_output("lit_t1_last", last_latency, 4);
      check_output("lit_t1_sum",  latency_sum,  4);

      $display("[TB] 3-flit packet with timestamp wrap and enable gaps");
      apply_stimulus(mk_flit(1, 0, 1, 8'hCA, 10'd1020, 10'd3), 10'd1020, 1, 0);
      apply_stimulus(mk_flit(0, 1, 0, 8'hCA, 10'd0, 10'd0), 10'd1021, 0, 0);
      apply_stimulus(mk_flit(0, 0, 0, 8'hCA, 10'd0, 10'd0), 10'd2, 1, 0);
      apply_stimulus(mk_flit(1, 1, 1, 8'hCA, 10'd0, 10'd1), 10'd3, 0, 0);
      apply_stimulus(mk_flit(0, 1, 0, 8'hCA, 10'd0, 10'd0), 10'd5, 1, 0);
      idle_cycle();
      check_output("lit_t2_last", last_latency, 9);
      check_output("lit_t2_sum",  latency_sum,  13);
      check_output("lit_t2_err",  rx_error,     0);
      check_output("lit_t2_pkts", rx_packets,   2);

      $display("[TB] length error then good packet");
      apply_stimulus(mk_flit(1, 0, 1, 8'hCA, 10'd20, 10'd3), 10'd20, 1, 0);
      apply_stimulus(mk_flit(0, 1, 0, 8'hCA, 10'd0, 10'd0), 10'd21, 1, 0);
      idle_cycle();
      check_output("lit_t3_err",  rx_error,   3'b100);
      check_output("lit_t3_pkts", rx_packets, 2);
      apply_stimulus(mk_flit(1, 0, 0, 8'hCA, 10'd30, 10'd2), 10'd30, 1, 0);
      apply_stimulus(mk_flit(0, 1, 0, 8'hCA, 10'd0, 10'd0), 10'd31, 1, 0);
      idle_cycle();
      check_output("lit_t3_pkts2", rx_packets,  3);
      check_output("lit_t3_meas",  rx_measured, 2);

      $display("[TB] sequence errors");
      apply_stimulus(mk_flit(0, 0, 0, 8'hCA, 10'd0, 10'd0), 10'd40, 1, 0);
      idle_cycle();
      check_output("lit_t4_err", rx_error, 3'b110);
      apply_stimulus(mk_flit(1, 0, 0, 8'hCA, 10'd40, 10'd3), 10'd40, 1, 0);
      apply_stimulus(mk_flit(0, 0, 0, 8'hCA, 10'd0, 10'd0), 10'd41, 1, 0);
      apply_stimulus(mk_flit(1, 0, 1, 8'hCA, 10'd10, 10'd2), 10'd12, 1, 0);
      apply_stimulus(mk_flit(0, 1, 0, 8'hCA, 10'd0, 10'd0), 10'd15, 1, 0);
      idle_cycle();
      check_output("lit_t4_pkts", rx_packets,   4);
      check_output("lit_t4_last", last_latency, 5);
      check_output("lit_t4_sum",  latency_sum,  18);

      $display("[TB] dest mismatch and saturation");
      apply_stimulus(mk_flit(1, 1, 1, 8'hCB, 10'd50, 10'd1), 10'd55, 1, 0);
      idle_cycle();
      check_output("lit_t5_err",  rx_error,    3'b111);
      check_output("lit_t5_pkts", rx_packets,  4);
      check_output("lit_t5_done", packet_done, 0);
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(mk_flit(1, 1, 1, 8'hCA, 10'd0, 10'd1), 10'd1000, 1, 0);
      end
      idle_cycle();
      check_output("lit_sat_sum",   latency_sum, 3018);
      check_output("lit_sat_small", s_sum,       11'h7FF);
      check_output("lit_sat_pkts",  rx_packets,  7);

      $display("[TB] clear_stats coincident with tail");
      apply_stimulus(mk_flit(1, 0, 1, 8'hCA, 10'd0, 10'd2), 10'd60, 1, 0);
      apply_stimulus(mk_flit(0, 1, 0, 8'hCA, 10'd0, 10'd0), 10'd70, 1, 1);
      idle_cycle();
      check_output("lit_clr_done", packet_done, 1);
      check_output("lit_clr_pkts", rx_packets,  0);
      check_output("lit_clr_sum",  latency_sum, 0);
      check_output("lit_clr_err",  rx_error,    0);
      check_output("lit_clr_max",  max_latency, 0);

      $display("[TB] max latency tracking");
      apply_stimulus(mk_flit(1, 1, 1, 8'hCA, 10'd100, 10'd1), 10'd105, 1, 0);
      apply_stimulus(mk_flit(1, 1, 1, 8'hCA, 10'd200, 10'd1), 10'd212, 1, 0);
      apply_stimulus(mk_flit(1, 1, 1, 8'hCA, 10'd300, 10'd1), 10'd303, 1, 0);
      idle_cycle();
      check_output("lit_max_meas", rx_measured,  3);
      check_output("lit_max_sum",  latency_sum,  20);
      check_output("lit_max_last", last_latency, 3);
`ifdef TG_SINK_MAX_LATENCY_EN
      check_output("lit_max_val", max_latency, 12);
`else
      check_output("lit_max_val", max_latency, 0);
`endif

      $display("[TB] reset mid-packet and zero psize");
      apply_stimulus(mk_flit(1, 0, 1, 8'hCA, 10'd400, 10'd3), 10'd400, 1, 0);
      apply_stimulus(mk_flit(0, 0, 0, 8'hCA, 10'd0, 10'd0), 10'd401, 1, 0);
      reset = 1'b1;
      idle_cycle();
      reset = 1'b0;
      apply_stimulus(mk_flit(0, 1, 0, 8'hCA, 10'd0, 10'd0), 10'd402, 1, 0);
      idle_cycle();
      check_output("lit_rst_err",  rx_error,   3'b010);
      check_output("lit_rst_pkts", rx_packets, 0);
      apply_stimulus(mk_flit(1, 1, 0, 8'hCA, 10'd0, 10'd0), 10'd403, 1, 0);
      idle_cycle();
      check_output("lit_ps0_err", rx_error, 3'b110);
      idle_cycle();
      idle_cycle();

      chk_on = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
